// File: rtl/lcd_bus_engine.sv
// HD44780-class LCD bus engine: byte read/write requests over valid/ready become RS/RW/E strobes
// on an 8-bit or 4-bit split data bus, with optional bounded busy-flag polling after the transfer.
module lcd_bus_engine #(
  parameter int unsigned SETUP_CYC        = 1500,
  parameter int unsigned PULSE_CYC        = 500,
  parameter int unsigned HOLD_CYC         = 1500,
  parameter int unsigned BUSY_TIMEOUT_CYC = 2000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_rw,
  input  logic [7:0] req_data,
  input  logic       req_nibble_only,
  input  logic       req_wait_busy,
  input  logic       mode4bit,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic [7:0] LCD_D_OUT,
  output logic       LCD_D_OE,
  input  logic [7:0] LCD_D_IN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E
);

  typedef enum logic [2:0] {StIdle, StSetup, StEHigh, StHold, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        nib_q, nib_d;
  logic        poll_q, poll_d;
  logic [7:0]  rd_q, rd_d;
  logic        tmo_q, tmo_d;

  logic        rs_q, rw_q, nib_only_q, wait_q, m4_q;
  logic [7:0]  data_q;

  logic        accept, busy_phase, cur_rs, cur_rw, two_nib, timed_out;
  logic [7:0]  wr_byte;

  assign accept     = req_valid && (state_q == StIdle);
  assign busy_phase = (state_q == StSetup) || (state_q == StEHigh) || (state_q == StHold);
  // Status polls always read the instruction register.
  assign cur_rs     = poll_q ? 1'b0 : rs_q;
  assign cur_rw     = poll_q | rw_q;
  assign two_nib    = m4_q && (cur_rw || !nib_only_q);
  assign timed_out  = to_cnt_q >= BUSY_TIMEOUT_CYC - 1;
  assign wr_byte    = !m4_q ? data_q :
                      nib_q ? {data_q[3:0], 4'h0} : {data_q[7:4], 4'h0};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      nib_only_q <= 1'b0;
      wait_q     <= 1'b0;
      m4_q       <= 1'b0;
      data_q     <= 8'h00;
    end else if (accept) begin
      rs_q       <= req_rs;
      rw_q       <= req_rw;
      nib_only_q <= req_nibble_only;
      wait_q     <= req_wait_busy;
      m4_q       <= mode4bit;
      data_q     <= req_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      nib_q    <= 1'b0;
      poll_q   <= 1'b0;
      rd_q     <= 8'h00;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      nib_q    <= nib_d;
      poll_q   <= poll_d;
      rd_q     <= rd_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_cnt_d    = to_cnt_q;
    nib_d       = nib_q;
    poll_d      = poll_q;
    rd_d        = rd_q;
    tmo_d       = tmo_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = 8'h00;
    rsp_timeout = 1'b0;
    LCD_D_OUT   = 8'h00;
    LCD_D_OE    = 1'b0;
    LCD_RS      = 1'b0;
    LCD_RW      = 1'b0;
    LCD_E       = 1'b0;

    // OE is the inverse of RW, so the bus turns around in the same cycle RW changes.
    if (busy_phase) begin
      LCD_RS    = cur_rs;
      LCD_RW    = cur_rw;
      LCD_D_OE  = !cur_rw;
      LCD_D_OUT = cur_rw ? 8'h00 : wr_byte;
      if (poll_q && (to_cnt_q < BUSY_TIMEOUT_CYC)) to_cnt_d = to_cnt_q + 1;
    end

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d  = StSetup;
          cnt_d    = '0;
          to_cnt_d = '0;
          nib_d    = 1'b0;
          poll_d   = 1'b0;
          rd_d     = 8'h00;
          tmo_d    = 1'b0;
        end
      end
      StSetup: begin
        if (cnt_q == SETUP_CYC - 1) begin
          state_d = StEHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      StEHigh: begin
        LCD_E = 1'b1;
        if (cnt_q == PULSE_CYC - 1) begin
          state_d = StHold;
          cnt_d   = '0;
          if (cur_rw) begin
            if (!m4_q)       rd_d      = LCD_D_IN;
            else if (!nib_q) rd_d[7:4] = LCD_D_IN[7:4];
            else             rd_d[3:0] = LCD_D_IN[7:4];
          end
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      StHold: begin
        if (cnt_q == HOLD_CYC - 1) begin
          cnt_d = '0;
          if (two_nib && !nib_q) begin
            state_d = StSetup;
            nib_d   = 1'b1;
          end else if (!poll_q && wait_q) begin
            state_d = StSetup;
            poll_d  = 1'b1;
            nib_d   = 1'b0;
          end else if (poll_q && rd_q[7] && !timed_out) begin
            state_d = StSetup;
            nib_d   = 1'b0;
          end else begin
            state_d = StDone;
            tmo_d   = poll_q && rd_q[7];
          end
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      StDone: begin
        rsp_valid   = 1'b1;
        rsp_data    = rd_q;
        rsp_timeout = tmo_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: doc/lcd_bus_engine.md
# lcd_bus_engine

Parametrised HD44780-class LCD bus engine: accepts byte-level read/write requests over a valid/ready handshake and drives RS/RW/E and an 8-bit data bus in either 8-bit or 4-bit (nibble) mode. Adds split-bus tristate control, data/status readback, and bounded busy-flag polling with timeout. Sits between the LCD init/command sequencer and the LCD pins.

## Interface
Parameters:
- SETUP_CYC, 1500: cycles RS/RW/data are stable before E rises (30 µs at 50 MHz); ≥1
- PULSE_CYC, 500: cycles E is high (10 µs); ≥1
- HOLD_CYC, 1500: cycles after E falls before the next phase (30 µs); ≥1
- BUSY_TIMEOUT_CYC, 2000000: maximum busy-poll duration (40 ms); ≥1

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle, accepts request
- req_rs  in  1  RS value (0 = instruction, 1 = data)
- req_rw  in  1  0 = write, 1 = read
- req_data  in  8  write byte
- req_nibble_only  in  1  4-bit mode, write: send only req_data[7:4], one E pulse
- req_wait_busy  in  1  poll busy flag after the transfer
- mode4bit  in  1  bus mode, sampled at accept
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  read byte, or last status byte when polling
- rsp_timeout  out  1  valid with rsp_valid: busy poll timed out
- LCD_D_OUT  out  8  data bus drive value
- LCD_D_OE  out  1  data bus output enable
- LCD_D_IN  in  8  data bus sampled value
- LCD_RS, LCD_RW, LCD_E  out  1  LCD control pins

## Operation
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_timeout=0, LCD_D_OUT=0, LCD_D_OE=0, LCD_RS=0, LCD_RW=0, LCD_E=0. State IDLE; timers cleared.
- States: IDLE, SETUP, E_HIGH, HOLD, DONE. Separate flags track the nibble index (0 = high, 1 = low) and phase (XFER or POLL).
- IDLE: on req_valid && req_ready, latch all req_* fields and mode4bit. Enter SETUP/XFER, nibble 0.
- SETUP: drive RS and RW. Write: LCD_D_OE=1 and LCD_D_OUT set. Read: LCD_D_OE=0. After SETUP_CYC cycles go to E_HIGH.
- E_HIGH: LCD_E=1 for PULSE_CYC cycles. Reads capture LCD_D_IN on the final E-high cycle. Then go to HOLD with E=0, bus and RS/RW unchanged.
- HOLD: after HOLD_CYC cycles:
  - If a 4-bit byte transfer and nibble 0 is done, go to SETUP for nibble 1.
  - Else, if XFER and wait_busy, go to SETUP/POLL.
  - Else, if POLL and BF=1 and not timed out, go to SETUP/POLL again.
  - Else go to DONE.
- 8-bit mode: LCD_D_OUT = byte; read capture = LCD_D_IN[7:0].
- 4-bit mode: LCD_D_OUT = {nibble, 4'b0}, high nibble first. Read: rsp_data[7:4] from the first pulse, rsp_data[3:0] from the second, both from LCD_D_IN[7:4].
- req_nibble_only: one pulse in 4-bit mode; ignored in 8-bit mode. Ignored on reads.
- POLL: RS=0, RW=1, OE=0. The full status byte is read (two pulses in 4-bit mode). BF = status[7].
- Timeout: a counter starts on the first POLL SETUP cycle. When it reaches BUSY_TIMEOUT_CYC, the current poll completes, then the engine goes to DONE with rsp_timeout=1.
- DONE, one cycle: rsp_valid=1, LCD_RW=0, OE=0, E=0. rsp_data is:
  - the read byte, for reads;
  - the last status byte, after polling;
  - otherwise 8'h00.
  Next state IDLE.

## Timing
- Accept at cycle 0. SETUP occupies cycles 1..S. E is high S+1..S+P. HOLD is S+P+1..S+P+H. Here S=SETUP_CYC, P=PULSE_CYC, H=HOLD_CYC, T=S+P+H.
- Latency to rsp_valid:
  - 8-bit or nibble-only write: 1+T cycles.
  - 4-bit byte: 1+2T cycles.
  - Each poll iteration adds T (8-bit) or 2T (4-bit).
- req_ready=0 from cycle 1 through DONE; it is 1 again in the cycle after DONE. Back-to-back accepts are therefore spaced by latency+1.
- req_valid while not ready is ignored; requests are not queued.
- Bus turnaround: LCD_D_OE drops in the same cycle LCD_RW rises. LCD_RW falls no earlier than the cycle OE rises, so the engine never drives while RW=1.
- mode4bit and req_* changes after accept have no effect.
- RST_N low mid-transfer: all outputs go to reset values asynchronously (E drops immediately), and any in-flight response is discarded.

## Test plan
Bench parameters: S=3, P=2, H=3, TIMEOUT=40.
- 8-bit write, req_data=8'hA5, rs=1: D_OUT=A5 and OE=1 at cycle 1. E high at cycles 4–5. rsp_valid at cycle 9, rsp_data=00.
- 4-bit write 8'h3C: two E pulses (cycles 4–5 and 12–13) with D_OUT=30 then C0. rsp_valid at cycle 17.
- 4-bit read: LCD_D_IN=8'h70 during pulse 1, then 8'h90 during pulse 2, so rsp_data=8'h79. OE=0 and RW=1 throughout.
- 8-bit write with wait_busy: LCD_D_IN=8'h85 for 2 polls, then 8'h05. Three status pulses occur, then rsp_data=05, rsp_timeout=0.
- Stuck BF: LCD_D_IN=8'h80 forever gives rsp_timeout=1, rsp_data=80, and rsp_valid within 40+T cycles of the first poll.
- Assert RST_N low while E=1: E=0 and OE=0 immediately, and req_ready=1 after release. A new request then completes normally.
